// File: rtl/stack_pkg.sv
// Shared opcodes and sequencer states for the stack controller and the main controller.
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_TOS  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RSP   = 3'd4
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack pointer owner and sequencer for a single-port sync-read stack RAM; optional hwm output under STACK_CTRL_HWM_EN.
// Latency: PUSH response at T+2, POP/TOS at T+3, errors at T+1 after command acceptance.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W:0]   sp,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef STACK_CTRL_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                pop_q, pop_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W:0]     sp_m1;

    assign sp_m1    = sp_q - ONE;
    assign sp       = sp_q;
    assign empty    = (sp_q == '0);
    assign full     = (sp_q == DEPTH);
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        opnd_d     = opnd_q;
        pop_d      = pop_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    opnd_d = cmd_data;
                    pop_d  = (cmd_op == OP_POP);
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                rsp_err_d  = 1'b1;
                                rsp_data_d = '0;
                                state_d    = RSP;
                            end else begin
                                state_d = WR;
                            end
                        end
                        OP_POP, OP_TOS: begin
                            if (empty) begin
                                rsp_err_d  = 1'b1;
                                rsp_data_d = '0;
                                state_d    = RSP;
                            end else begin
                                state_d = RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WR: begin
                mem_we     = 1'b1;
                mem_addr   = sp_q[ADDR_W-1:0];
                mem_wdata  = opnd_q;
                sp_d       = sp_q + ONE;
                rsp_err_d  = 1'b0;
                rsp_data_d = '0;
                state_d    = RSP;
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = sp_m1[ADDR_W-1:0];
                // TOS peeks: same read as POP, pointer untouched
                if (pop_q) begin
                    sp_d = sp_m1;
                end
                state_d = RWAIT;
            end
            RWAIT: begin
                rsp_data_d = mem_rdata;
                rsp_err_d  = 1'b0;
                state_d    = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sp_q       <= '0;
            opnd_q     <= '0;
            pop_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            opnd_q     <= opnd_d;
            pop_q      <= pop_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef STACK_CTRL_HWM_EN
    logic [ADDR_W:0] hwm_q, hwm_d;

    // sp only grows in WR, so tracking sp_d every cycle captures every new peak
    always_comb begin
        hwm_d = hwm_q;
        if (sp_d > hwm_q) begin
            hwm_d = sp_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 1-cycle-latency RAM and a response scoreboard.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] sp;
    logic       empty, full;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata;
`ifdef STACK_CTRL_HWM_EN
    logic [4:0] hwm;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } rsp_t;
    rsp_t sb[$];

    logic [7:0] ram [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    stack_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
`ifdef STACK_CTRL_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the response handshake.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] d,
                           input int exp_lat, input logic [7:0] exp_d, input logic exp_e,
                           input logic exp_we, input logic exp_re, input logic [3:0] exp_addr,
                           input int hold);
        rsp_t       r;
        int         n;
        bit         got, saw_we, saw_re, both;
        logic [3:0] addr_s;
        got = 0; saw_we = 0; saw_re = 0; both = 0; addr_s = '0;
        sb.push_back('{d: exp_d, e: exp_e});
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        check({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        n = 1;
        while (!got && n <= 10) begin
            if (mem_we && mem_re) both = 1;
            if (mem_we) begin
                saw_we = 1;
                addr_s = mem_addr;
                check({tag, ".wdata"}, {24'd0, mem_wdata}, {24'd0, d});
            end
            if (mem_re) begin
                saw_re = 1;
                addr_s = mem_addr;
            end
            if (rsp_valid) got = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        r = sb.pop_front();
        check({tag, ".rsp_seen"}, {31'd0, got}, 32'd1);
        check({tag, ".latency"}, n, exp_lat);
        check({tag, ".we_seen"}, {31'd0, saw_we}, {31'd0, exp_we});
        check({tag, ".re_seen"}, {31'd0, saw_re}, {31'd0, exp_re});
        check({tag, ".we_re_excl"}, {31'd0, both}, 32'd0);
        if (exp_we || exp_re) check({tag, ".addr"}, {28'd0, addr_s}, {28'd0, exp_addr});
        if (got) begin
            for (int i = 0; i < hold; i++) begin
                check({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({tag, ".hold_err"}, {31'd0, rsp_err}, {31'd0, r.e});
                check({tag, ".hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            check({tag, ".rsp_data"}, {24'd0, rsp_data}, {24'd0, r.d});
            check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, r.e});
            check({tag, ".busy_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            check({tag, ".post_valid"}, {31'd0, rsp_valid}, 32'd0);
            check({tag, ".post_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst.we", {31'd0, mem_we}, 32'd0);
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle.sp", {27'd0, sp}, 32'd0);
        check("idle.empty", {31'd0, empty}, 32'd1);
        check("idle.full", {31'd0, full}, 32'd0);
        check("idle.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle.strobes", {30'd0, mem_we, mem_re}, 32'd0);
        check("idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef STACK_CTRL_HWM_EN
        check("idle.hwm", {27'd0, hwm}, 32'd0);
`endif

        run_cmd("push11", OP_PUSH, 8'h11, 2, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 0);
        run_cmd("push22", OP_PUSH, 8'h22, 2, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 0);
        check("push2.sp", {27'd0, sp}, 32'd2);
        run_cmd("pop22", OP_POP, 8'h00, 3, 8'h22, 1'b0, 1'b0, 1'b1, 4'd1, 0);
        run_cmd("pop11", OP_POP, 8'h00, 3, 8'h11, 1'b0, 1'b0, 1'b1, 4'd0, 0);
        check("pop2.sp", {27'd0, sp}, 32'd0);

        cmd_valid = 1'b1;
        cmd_op    = OP_NOP;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("nop.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("nop.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        run_cmd("push5a", OP_PUSH, 8'h5A, 2, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 0);
        run_cmd("tos5a", OP_TOS, 8'h00, 3, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd0, 0);
        check("tos.sp", {27'd0, sp}, 32'd1);
        run_cmd("pop5a", OP_POP, 8'h00, 3, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd0, 0);
        check("pop5a.sp", {27'd0, sp}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_cmd("fill", OP_PUSH, 8'h80 + 8'(i), 2, 8'h00, 1'b0, 1'b1, 1'b0, 4'(i), 0);
        end
        check("fill.full", {31'd0, full}, 32'd1);
        check("fill.sp", {27'd0, sp}, 32'd16);
        check("fill.empty", {31'd0, empty}, 32'd0);
        run_cmd("overflow", OP_PUSH, 8'hEE, 1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 0);
        check("overflow.sp", {27'd0, sp}, 32'd16);
`ifdef STACK_CTRL_HWM_EN
        check("fill.hwm", {27'd0, hwm}, 32'd16);
`endif

        for (int i = 15; i >= 0; i--) begin
            run_cmd("drain", OP_POP, 8'h00, 3, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b1, 4'(i), 0);
        end
        check("drain.sp", {27'd0, sp}, 32'd0);
        check("drain.empty", {31'd0, empty}, 32'd1);
`ifdef STACK_CTRL_HWM_EN
        check("drain.hwm", {27'd0, hwm}, 32'd16);
`endif

        run_cmd("underflow", OP_POP, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 5);
        run_cmd("tos_empty", OP_TOS, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 0);
        check("underflow.sp", {27'd0, sp}, 32'd0);

        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 8'h77;
        @(posedge clk);
        #1;
        check("rstmid.we_before", {31'd0, mem_we}, 32'd1);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rstmid.we_after", {31'd0, mem_we}, 32'd0);
        check("rstmid.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rstmid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.sp", {27'd0, sp}, 32'd0);
        check("rstmid.empty", {31'd0, empty}, 32'd1);
        check("rstmid.idle", {31'd0, cmd_ready}, 32'd1);
        check("rstmid.err", {31'd0, rsp_err}, 32'd0);
`ifdef STACK_CTRL_HWM_EN
        check("rstmid.hwm", {27'd0, hwm}, 32'd0);
`endif
        run_cmd("post_rst_pop", OP_POP, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
